// File: rtl/iter_divider.sv
// Radix-2 restoring divider with signed/unsigned mode, valid/ready handshakes on both sides,
// and separate divide-by-zero and signed-overflow flags. Latency is fixed by the operand width.
module iter_divider #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_signed,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int N  = DIVIDEND_WIDTH;
    localparam int M  = DIVISOR_WIDTH;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [N-1:0]  DIVIDEND_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] COUNT_INIT   = CW'(N);
    localparam logic [CW-1:0] COUNT_ONE    = CW'(1);

    logic [1:0]    state;
    logic [N-1:0]  a;
    logic [M-1:0]  b;
    logic [M-1:0]  pr;
    logic [CW-1:0] count;
    logic          sign_q;
    logic          sign_r;
    logic          dz;
    logic          ovf;

    logic          dividend_neg;
    logic          divisor_neg;
    logic [N-1:0]  dividend_mag;
    logic [M-1:0]  divisor_mag;
    logic [M:0]    pr_shift;
    logic          pr_ge;
    logic [M-1:0]  pr_sub;

    assign dividend_neg = in_signed & dividend[N-1];
    assign divisor_neg  = in_signed & divisor[M-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg ? -divisor : divisor;

    // The remainder never reaches |b| after a step, so only the shifted value needs the extra bit.
    assign pr_shift = {pr, a[N-1]};
    assign pr_ge    = pr_shift >= {1'b0, b};
    assign pr_sub   = pr_shift[M-1:0] - b;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Quotient bits are shifted into the bottom of a as dividend bits leave the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            pr          <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            ovf         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q      <= dividend_neg ^ divisor_neg;
                        sign_r      <= dividend_neg;
                        b           <= divisor_mag;
                        pr          <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        dz          <= (divisor == '0);
                        ovf         <= in_signed && (dividend == DIVIDEND_MIN) && (divisor == '1);
                        // A zero divisor keeps the raw dividend so its low bits become the remainder.
                        if (divisor == '0) begin
                            a     <= dividend;
                            state <= FIX;
                        end else begin
                            a     <= dividend_mag;
                            count <= COUNT_INIT;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    a     <= {a[N-2:0], pr_ge};
                    pr    <= pr_ge ? pr_sub : pr_shift[M-1:0];
                    count <= count - COUNT_ONE;
                    if (count == COUNT_ONE) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= a[M-1:0];
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= sign_q ? -a : a;
                        remainder <= sign_r ? -pr : pr;
                    end
                    overflow <= ovf;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases with literal expectations, then
// randomized operations checked every DONE cycle against an arithmetic reference model.
module tb_iter_divider;

    localparam int N = 32;
    localparam int M = 32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } result_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [N-1:0]  dividend = '0;
    logic [M-1:0]  divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  quotient;
    logic [M-1:0]  remainder;
    logic          div_by_zero;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    result_t       exp_q[$];

    iter_divider #(
        .DIVIDEND_WIDTH(N),
        .DIVISOR_WIDTH (M)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Plain integer division in 64 bits: SV '/' and '%' truncate toward zero and the
    // remainder takes the dividend's sign, which is exactly the required result.
    function automatic result_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        result_t res;
        longint  sa;
        longint  sb;
        longint  sq;
        longint  sr;
        res.dz = (b == 32'd0);
        res.ov = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = a;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            sq = sa / sb;
            sr = sa % sb;
            res.q = sq[31:0];
            res.r = sr[31:0];
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkResult(input string name, input logic [31:0] q, input logic [31:0] r,
                               input logic dz, input logic ov);
        checkOutput({name, "_q"}, quotient, q);
        checkOutput({name, "_r"}, remainder, r);
        checkOutput({name, "_dz"}, 32'(div_by_zero), 32'(dz));
        checkOutput({name, "_ov"}, 32'(overflow), 32'(ov));
    endtask

    // One full transaction: accept, measure latency, optionally stall in DONE, then handshake.
    task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 input int hold, input bit pulse);
        int      lat;
        int      wait_cnt;
        result_t expect_res;
        expect_res = model(sgn, a, b);
        in_signed  = sgn;
        dividend   = a;
        divisor    = b;
        in_valid   = 1'b1;
        out_ready  = (hold == 0);
        wait_cnt   = 0;
        while (!in_ready && wait_cnt < 100) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(expect_res);
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        in_signed = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), (b == 32'd0) ? 32'd2 : 32'(N + 2));
        if (!out_valid) begin
            exp_q.delete();
            return;
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (pulse) begin
                    in_valid = 1'($urandom_range(0, 1));
                    dividend = $urandom;
                    divisor  = $urandom;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("in_ready_after_done", 32'(in_ready), 32'd1);
        checkOutput("out_valid_after_done", 32'(out_valid), 32'd0);
    endtask

    // Every DONE cycle must present the oldest outstanding expected result, with in_ready low.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
                checkOutput("cmp_quotient", quotient, exp_q[0].q);
                checkOutput("cmp_remainder", remainder, exp_q[0].r);
                checkOutput("cmp_div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dz));
                checkOutput("cmp_overflow", 32'(overflow), 32'(exp_q[0].ov));
                checkOutput("cmp_in_ready_done", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        result_t     pin;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        int          sel;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkResult("reset", 32'd0, 32'd0, 1'b0, 1'b0);

        pin = model(1'b0, 32'd100, 32'd7);
        checkOutput("model_q_100_7", pin.q, 32'd14);
        checkOutput("model_r_100_7", pin.r, 32'd2);
        pin = model(1'b1, 32'hFFFF_FFF9, 32'd2);
        checkOutput("model_q_m7_2", pin.q, 32'hFFFF_FFFD);
        checkOutput("model_r_m7_2", pin.r, 32'hFFFF_FFFF);
        pin = model(1'b1, 32'd7, 32'hFFFF_FFFE);
        checkOutput("model_q_7_m2", pin.q, 32'hFFFF_FFFD);
        checkOutput("model_r_7_m2", pin.r, 32'd1);
        pin = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("model_q_ovf", pin.q, 32'h8000_0000);
        checkOutput("model_ov_ovf", 32'(pin.ov), 32'd1);

        applyStimulus(1'b0, 32'd100, 32'd7, 0, 1'b0);
        checkResult("u100_7", 32'd14, 32'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        checkResult("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        checkResult("u_fff9_2", 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd5, 32'd0, 0, 1'b0);
        checkResult("u5_0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd5, 32'd0, 0, 1'b0);
        checkResult("s5_0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        checkResult("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        checkResult("u_ovf_ops", 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd1000, 32'd10, 10, 1'b1);
        checkResult("hold10", 32'd100, 32'd0, 1'b0, 1'b0);

        // Abort an operation partway through CALC; nothing from it may ever surface.
        in_signed = 1'b0;
        dividend  = 32'h1234_5678;
        divisor   = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkResult("midreset", 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        checkResult("after_reset", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 9));
            rs  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = 32'd0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = ~32'($urandom_range(0, 14));
                4: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            applyStimulus(rs, ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
